// File: rtl/alu_pkg.sv
// Shared ALU op codes, forwarding-select encoding and datapath defaults for the
// ID/EX operand stage.
package alu_pkg;

  localparam int XLEN_DEFAULT       = 32;
  localparam int REG_ADDR_W_DEFAULT = 5;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  typedef enum logic [1:0] {
    FWD_REG,
    FWD_EXMEM,
    FWD_MEMWB
  } fwd_sel_t;

endpackage

// File: rtl/operand_fwd_sel.sv
// Per-operand RAW match against EX/MEM and MEM/WB: picks a bypass source and flags a stall.
// Behaviour depends on ALU_FWD_EN (bypass + load-use stall vs. stall on any match).
module operand_fwd_sel
  import alu_pkg::*;
#(
  parameter int REG_ADDR_W = REG_ADDR_W_DEFAULT
) (
  input  logic [REG_ADDR_W-1:0] rs,
  input  logic                  used,
  input  logic [REG_ADDR_W-1:0] exmem_rd,
  input  logic                  exmem_reg_write,
  input  logic                  exmem_mem_read,
  input  logic [REG_ADDR_W-1:0] memwb_rd,
  input  logic                  memwb_reg_write,
  output fwd_sel_t              sel,
  output logic                  hazard
);

  logic match_exmem;
  logic match_memwb;

  // x0 is hardwired, so it never matches a producer.
  assign match_exmem = exmem_reg_write & (exmem_rd == rs) & (rs != '0);
  assign match_memwb = memwb_reg_write & (memwb_rd == rs) & (rs != '0);

`ifdef ALU_FWD_EN
  always_comb begin
    sel = FWD_REG;
    if (match_exmem)      sel = FWD_EXMEM;
    else if (match_memwb) sel = FWD_MEMWB;
  end

  assign hazard = used & match_exmem & exmem_mem_read;
`else
  logic unused_mem_read;

  assign unused_mem_read = exmem_mem_read;
  assign sel             = FWD_REG;
  assign hazard          = used & (match_exmem | match_memwb);
`endif

endmodule

// File: rtl/id_ex_operand_stage.sv
// ID/EX pipeline register with operand forwarding, write-back snooping, load-use stall
// and branch flush. ALU_FWD_EN enables the EX/MEM and MEM/WB bypass muxes.
module id_ex_operand_stage
  import alu_pkg::*;
#(
  parameter int XLEN       = XLEN_DEFAULT,
  parameter int REG_ADDR_W = REG_ADDR_W_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [REG_ADDR_W-1:0] in_rs1,
  input  logic [REG_ADDR_W-1:0] in_rs2,
  input  logic [XLEN-1:0]       in_rs1_data,
  input  logic [XLEN-1:0]       in_rs2_data,
  input  logic [XLEN-1:0]       in_imm,
  input  logic                  in_use_imm,
  input  logic [2:0]            in_alu_control,
  input  logic [REG_ADDR_W-1:0] in_rd,
  input  logic                  in_reg_write,
  input  logic                  in_mem_read,
  input  logic [REG_ADDR_W-1:0] exmem_rd,
  input  logic                  exmem_reg_write,
  input  logic                  exmem_mem_read,
  input  logic [XLEN-1:0]       exmem_result,
  input  logic [REG_ADDR_W-1:0] memwb_rd,
  input  logic                  memwb_reg_write,
  input  logic [XLEN-1:0]       memwb_result,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [XLEN-1:0]       alu_a,
  output logic [XLEN-1:0]       alu_b,
  output logic [2:0]            alu_control,
  output logic [REG_ADDR_W-1:0] out_rd,
  output logic                  out_reg_write,
  output logic                  out_mem_read,
  output logic                  hazard_stall
);

  logic                  held_valid;
  logic [REG_ADDR_W-1:0] held_rs1, held_rs2;
  logic [XLEN-1:0]       held_rs1_data, held_rs2_data, held_imm;
  logic                  held_use_imm;

  fwd_sel_t sel_a, sel_b;
  logic     hazard_a, hazard_b;
  logic     capture;
  logic     snoop_in1, snoop_in2, snoop_held1, snoop_held2;
  logic [XLEN-1:0] fwd_rs2;

  operand_fwd_sel #(.REG_ADDR_W(REG_ADDR_W)) u_fwd_rs1 (
    .rs(held_rs1), .used(1'b1),
    .exmem_rd(exmem_rd), .exmem_reg_write(exmem_reg_write), .exmem_mem_read(exmem_mem_read),
    .memwb_rd(memwb_rd), .memwb_reg_write(memwb_reg_write),
    .sel(sel_a), .hazard(hazard_a)
  );

  operand_fwd_sel #(.REG_ADDR_W(REG_ADDR_W)) u_fwd_rs2 (
    .rs(held_rs2), .used(~held_use_imm),
    .exmem_rd(exmem_rd), .exmem_reg_write(exmem_reg_write), .exmem_mem_read(exmem_mem_read),
    .memwb_rd(memwb_rd), .memwb_reg_write(memwb_reg_write),
    .sel(sel_b), .hazard(hazard_b)
  );

  assign hazard_stall = held_valid & (hazard_a | hazard_b);
  assign out_valid    = held_valid & ~hazard_stall;
  assign in_ready     = ~held_valid | (out_valid & out_ready);
  assign capture      = in_valid & in_ready;

  // Write-back snooping stands in for a register file that is written at the same edge.
  assign snoop_in1   = memwb_reg_write & (memwb_rd == in_rs1) & (in_rs1 != '0);
  assign snoop_in2   = memwb_reg_write & (memwb_rd == in_rs2) & (in_rs2 != '0);
  assign snoop_held1 = memwb_reg_write & (memwb_rd == held_rs1) & (held_rs1 != '0);
  assign snoop_held2 = memwb_reg_write & (memwb_rd == held_rs2) & (held_rs2 != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      held_valid    <= 1'b0;
      held_rs1      <= '0;
      held_rs2      <= '0;
      held_rs1_data <= '0;
      held_rs2_data <= '0;
      held_imm      <= '0;
      held_use_imm  <= 1'b0;
      alu_control   <= '0;
      out_rd        <= '0;
      out_reg_write <= 1'b0;
      out_mem_read  <= 1'b0;
    end else if (capture) begin
      // A flushed capture is still consumed from decode, just never presented.
      held_valid    <= ~flush;
      held_rs1      <= in_rs1;
      held_rs2      <= in_rs2;
      held_rs1_data <= snoop_in1 ? memwb_result : in_rs1_data;
      held_rs2_data <= snoop_in2 ? memwb_result : in_rs2_data;
      held_imm      <= in_imm;
      held_use_imm  <= in_use_imm;
      alu_control   <= in_alu_control;
      out_rd        <= in_rd;
      out_reg_write <= in_reg_write;
      out_mem_read  <= in_mem_read;
    end else begin
      if (flush || (out_valid && out_ready)) held_valid <= 1'b0;
      if (held_valid && snoop_held1) held_rs1_data <= memwb_result;
      if (held_valid && snoop_held2) held_rs2_data <= memwb_result;
    end
  end

  always_comb begin
    alu_a = held_rs1_data;
    case (sel_a)
      FWD_EXMEM: alu_a = exmem_result;
      FWD_MEMWB: alu_a = memwb_result;
      default:   alu_a = held_rs1_data;
    endcase
  end

  always_comb begin
    fwd_rs2 = held_rs2_data;
    case (sel_b)
      FWD_EXMEM: fwd_rs2 = exmem_result;
      FWD_MEMWB: fwd_rs2 = memwb_result;
      default:   fwd_rs2 = held_rs2_data;
    endcase
  end

  assign alu_b = held_use_imm ? held_imm : fwd_rs2;

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// Scoreboard bench for id_ex_operand_stage; expectations follow ALU_FWD_EN when defined.
module tb_id_ex_operand_stage;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n, flush, in_valid, in_ready;
  logic [4:0]  in_rs1, in_rs2, in_rd, exmem_rd, memwb_rd, out_rd;
  logic [31:0] in_rs1_data, in_rs2_data, in_imm, exmem_result, memwb_result, alu_a, alu_b;
  logic        in_use_imm, in_reg_write, in_mem_read;
  logic [2:0]  in_alu_control, alu_control;
  logic        exmem_reg_write, exmem_mem_read, memwb_reg_write;
  logic        out_valid, out_ready, out_reg_write, out_mem_read, hazard_stall;

  always #5 clk = ~clk;

  id_ex_operand_stage dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data),
    .in_imm(in_imm), .in_use_imm(in_use_imm), .in_alu_control(in_alu_control), .in_rd(in_rd),
    .in_reg_write(in_reg_write), .in_mem_read(in_mem_read),
    .exmem_rd(exmem_rd), .exmem_reg_write(exmem_reg_write), .exmem_mem_read(exmem_mem_read),
    .exmem_result(exmem_result), .memwb_rd(memwb_rd), .memwb_reg_write(memwb_reg_write),
    .memwb_result(memwb_result), .out_valid(out_valid), .out_ready(out_ready),
    .alu_a(alu_a), .alu_b(alu_b), .alu_control(alu_control), .out_rd(out_rd),
    .out_reg_write(out_reg_write), .out_mem_read(out_mem_read), .hazard_stall(hazard_stall)
  );

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  ctl;
    logic [4:0]  rd;
    logic        mr;
  } exp_t;

  exp_t sb[$];
  int n_cmp = 0;
  int n_err = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic offer(input logic [4:0] rs1, input logic [31:0] d1, input logic [4:0] rs2,
                       input logic [31:0] d2, input logic [31:0] imm, input logic use_imm,
                       input logic [2:0] ctl, input logic [4:0] rd, input logic mr);
    in_rs1 = rs1; in_rs1_data = d1; in_rs2 = rs2; in_rs2_data = d2;
    in_imm = imm; in_use_imm = use_imm; in_alu_control = ctl; in_rd = rd;
    in_reg_write = 1'b1; in_mem_read = mr; in_valid = 1'b1;
  endtask

  task automatic push_exp(input logic [31:0] a, input logic [31:0] b, input logic [2:0] ctl,
                          input logic [4:0] rd, input logic mr);
    exp_t e;
    e.a = a; e.b = b; e.ctl = ctl; e.rd = rd; e.mr = mr;
    sb.push_back(e);
  endtask

  task automatic set_exmem(input logic [4:0] rd, input logic rw, input logic mr, input logic [31:0] res);
    exmem_rd = rd; exmem_reg_write = rw; exmem_mem_read = mr; exmem_result = res;
  endtask

  task automatic set_memwb(input logic [4:0] rd, input logic rw, input logic [31:0] res);
    memwb_rd = rd; memwb_reg_write = rw; memwb_result = res;
  endtask

  // Every transfer to EX/MEM is popped and compared against the scoreboard.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        check_val("unexpected_out", 32'(out_valid), 32'd0);
      end else begin
        e = sb.pop_front();
        check_val("alu_a", alu_a, e.a);
        check_val("alu_b", alu_b, e.b);
        check_val("alu_control", 32'(alu_control), 32'(e.ctl));
        check_val("out_rd", 32'(out_rd), 32'(e.rd));
        check_val("out_reg_write", 32'(out_reg_write), 32'd1);
        check_val("out_mem_read", 32'(out_mem_read), 32'(e.mr));
      end
    end
  end

  initial begin
    rst_n = 1'b0; flush = 1'b0; out_ready = 1'b1; in_valid = 1'b0;
    set_exmem(5'd0, 1'b0, 1'b0, 32'h0);
    set_memwb(5'd0, 1'b0, 32'h0);

    // Reset with an instruction already offered
    offer(5'd1, 32'hF0, 5'd2, 32'h3C, 32'h0, 1'b0, ALU_AND, 5'd3, 1'b0);
    push_exp(32'hF0, 32'h3C, ALU_AND, 5'd3, 1'b0);
    repeat (2) begin
      sample();
      check_val("rst_out_valid", 32'(out_valid), 32'd0);
      check_val("rst_alu_a", alu_a, 32'h0);
      check_val("rst_alu_b", alu_b, 32'h0);
      check_val("rst_alu_control", 32'(alu_control), 32'd0);
      check_val("rst_out_rd", 32'(out_rd), 32'd0);
      check_val("rst_ctrl", 32'({out_reg_write, out_mem_read, hazard_stall}), 32'd0);
    end
    step(); rst_n = 1'b1;
    step(); in_valid = 1'b0;
    sample(); check_val("t1_latency", 32'(out_valid), 32'd1);

    // Plain ADD, no producers in flight
    step();
    offer(5'd5, 32'd7, 5'd6, 32'd3, 32'h0, 1'b0, ALU_ADD, 5'd4, 1'b0);
    push_exp(32'd7, 32'd3, ALU_ADD, 5'd4, 1'b0);
    step(); in_valid = 1'b0;
    sample();
    check_val("t2_out_valid", 32'(out_valid), 32'd1);
    check_val("t2_stall", 32'(hazard_stall), 32'd0);

    // rs1 matches both EX/MEM and MEM/WB
    step();
    set_exmem(5'd5, 1'b1, 1'b0, 32'h10);
    set_memwb(5'd5, 1'b1, 32'h20);
    offer(5'd5, 32'h99, 5'd6, 32'd3, 32'h0, 1'b0, ALU_SUB, 5'd8, 1'b0);
`ifdef ALU_FWD_EN
    push_exp(32'h10, 32'd3, ALU_SUB, 5'd8, 1'b0);
    step(); in_valid = 1'b0;
    sample(); check_val("t3_stall", 32'(hazard_stall), 32'd0);
    step();
    set_exmem(5'd0, 1'b0, 1'b0, 32'h0); set_memwb(5'd0, 1'b0, 32'h0);
`else
    push_exp(32'h20, 32'd3, ALU_SUB, 5'd8, 1'b0);
    step(); in_valid = 1'b0;
    sample();
    check_val("t3_stall", 32'(hazard_stall), 32'd1);
    check_val("t3_stall_valid", 32'(out_valid), 32'd0);
    step();
    set_exmem(5'd0, 1'b0, 1'b0, 32'h0); set_memwb(5'd0, 1'b0, 32'h0);
    sample(); check_val("t3_resume", 32'(out_valid), 32'd1);
    step();
`endif

    // Load-use on rs2
    set_exmem(5'd7, 1'b1, 1'b1, 32'hDEAD);
    offer(5'd1, 32'd5, 5'd7, 32'h11, 32'h0, 1'b0, ALU_SUB, 5'd9, 1'b0);
    push_exp(32'd5, 32'hAB, ALU_SUB, 5'd9, 1'b0);
    step(); in_valid = 1'b0;
    sample();
    check_val("t4_stall", 32'(hazard_stall), 32'd1);
    check_val("t4_stall_valid", 32'(out_valid), 32'd0);
    step();
    set_exmem(5'd0, 1'b0, 1'b0, 32'h0); set_memwb(5'd7, 1'b1, 32'hAB);
    sample();
`ifdef ALU_FWD_EN
    check_val("t4_resume", 32'(out_valid), 32'd1);
    step(); set_memwb(5'd0, 1'b0, 32'h0);
`else
    check_val("t4_memwb_stall", 32'(hazard_stall), 32'd1);
    step(); set_memwb(5'd0, 1'b0, 32'h0);
    sample(); check_val("t4_resume", 32'(out_valid), 32'd1);
    step();
`endif

    // x0 sources never match, even with x0 producers in flight
    set_exmem(5'd0, 1'b1, 1'b1, 32'h55); set_memwb(5'd0, 1'b1, 32'h66);
    offer(5'd0, 32'h123, 5'd0, 32'h456, 32'h0, 1'b0, ALU_OR, 5'd10, 1'b0);
    push_exp(32'h123, 32'h456, ALU_OR, 5'd10, 1'b0);
    step(); in_valid = 1'b0;
    sample();
    check_val("t5_stall", 32'(hazard_stall), 32'd0);
    check_val("t5_out_valid", 32'(out_valid), 32'd1);
    step();

    // rs2 hidden behind the immediate is not checked
    set_exmem(5'd9, 1'b1, 1'b1, 32'h55); set_memwb(5'd0, 1'b0, 32'h0);
    offer(5'd3, 32'd4, 5'd9, 32'h77, 32'd8, 1'b1, ALU_SLT, 5'd11, 1'b1);
    push_exp(32'd4, 32'd8, ALU_SLT, 5'd11, 1'b1);
    step(); in_valid = 1'b0;
    sample();
    check_val("t5b_stall", 32'(hazard_stall), 32'd0);
    check_val("t5b_out_valid", 32'(out_valid), 32'd1);
    step(); set_exmem(5'd0, 1'b0, 1'b0, 32'h0);

    // Downstream backpressure, then flush of the held instruction
    offer(5'd10, 32'hA, 5'd11, 32'hB, 32'h0, 1'b0, ALU_ADD, 5'd12, 1'b0);
    out_ready = 1'b0;
    step();
    offer(5'd13, 32'hC, 5'd14, 32'hD, 32'h0, 1'b0, ALU_SUB, 5'd15, 1'b0);
    for (int i = 0; i < 3; i++) begin
      sample();
      check_val("t6_hold_valid", 32'(out_valid), 32'd1);
      check_val("t6_hold_in_ready", 32'(in_ready), 32'd0);
      check_val("t6_hold_a", alu_a, 32'hA);
      check_val("t6_hold_b", alu_b, 32'hB);
      check_val("t6_hold_rd", 32'(out_rd), 32'd12);
      step();
    end
    flush = 1'b1;
    sample(); check_val("t6_flush_cycle_valid", 32'(out_valid), 32'd1);
    step(); flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    sample(); check_val("t6_after_flush", 32'(out_valid), 32'd0);

    // Flush beats a same-cycle capture
    step();
    offer(5'd1, 32'h1, 5'd2, 32'h2, 32'h0, 1'b0, ALU_ADD, 5'd16, 1'b0);
    flush = 1'b1;
    sample(); check_val("t6_flush_in_ready", 32'(in_ready), 32'd1);
    step(); flush = 1'b0; in_valid = 1'b0;
    sample(); check_val("t6_dropped", 32'(out_valid), 32'd0);

    // Back-to-back: transfer and capture in the same cycle
    step();
    offer(5'd1, 32'd1, 5'd2, 32'd2, 32'h0, 1'b0, ALU_ADD, 5'd1, 1'b0);
    push_exp(32'd1, 32'd2, ALU_ADD, 5'd1, 1'b0);
    step();
    offer(5'd3, 32'h30, 5'd4, 32'h4, 32'h0, 1'b0, ALU_SUB, 5'd2, 1'b0);
    push_exp(32'h30, 32'h4, ALU_SUB, 5'd2, 1'b0);
    sample(); check_val("t7_in_ready", 32'(in_ready), 32'd1);
    step(); in_valid = 1'b0;
    sample(); check_val("t7_no_bubble", 32'(out_valid), 32'd1);
    step();

    for (int i = 0; i < 20 && sb.size() != 0; i++) sample();
    check_val("drain_empty", 32'(sb.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
